// File: rtl/cl_div_pkg.sv
// Shared types for the sequential integer / carry-less divider.
// Holds the FSM encoding and helpers for sizing the iteration counter.
package cl_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int CNT_W = $clog2(2 * DEF_DATA_WIDTH);

  // Counter width for a given divisor width; the quotient takes 2W steps.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/cl_div_step.sv
// One restoring-division iteration: conditional subtract (integer)
// or conditional XOR (carry-less) of the divisor from the partial remainder.
module cl_div_step #(
  parameter int DATA_WIDTH = 32,
  parameter int D_W = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH:0]   i_t,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  input  logic [D_W-1:0]        i_d,
  input  logic                  i_carry_option,
  output logic [DATA_WIDTH-1:0] o_rem_next,
  output logic                  o_qbit
);

  always_comb begin
    o_rem_next = i_t[DATA_WIDTH-1:0];
    o_qbit     = 1'b0;
    if (i_carry_option) begin
      if (i_t >= {1'b0, i_divisor}) begin
        o_rem_next = DATA_WIDTH'(i_t - {1'b0, i_divisor});
        o_qbit     = 1'b1;
      end
    end else begin
      // Bits of t above d are always zero, so the XOR never touches bit W.
      if (i_t[i_d]) begin
        o_rem_next = i_t[DATA_WIDTH-1:0] ^ i_divisor;
        o_qbit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cl_seq_div.sv
// Iterative divider producing one quotient bit per clock, in either
// unsigned integer or GF(2)[x] carry-less mode.
module cl_seq_div
  import cl_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      carry_option,
  input  logic [2*DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]     remainder,
  output logic                      div_by_zero,
  output logic [1:0]                o_dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int QW = 2 * DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam int DW = $clog2(DATA_WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and payload never changes until that edge.
  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [QW-1:0]   r_dividend, r_quot;
  logic [W-1:0]    r_divisor, r_rem;
  logic [DW-1:0]   r_d, w_msb;
  logic            r_mode, r_dbz;
  logic            w_last;
  logic [W:0]      w_t;
  logic [W-1:0]    w_rem_next;
  logic            w_qbit;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < W; i++) begin
      if (divisor[i]) w_msb = DW'(i);
    end
  end

  // The first step starts from a zero remainder without clearing r_rem on accept.
  assign w_last = (r_cnt == CW'(QW - 1));
  assign w_t    = {(r_cnt == '0) ? {W{1'b0}} : r_rem, r_dividend[QW-1]};

  cl_div_step #(.DATA_WIDTH(W), .D_W(DW)) u_step (
    .i_t            (w_t),
    .i_divisor      (r_divisor),
    .i_d            (r_d),
    .i_carry_option (r_mode),
    .o_rem_next     (w_rem_next),
    .o_qbit         (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_d        <= '0;
      r_mode     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_d        <= w_msb;
            r_mode     <= carry_option;
            r_cnt      <= '0;
            if (divisor == '0) begin
              r_quot <= '1;
              r_rem  <= dividend[W-1:0];
              r_dbz  <= 1'b1;
            end else begin
              r_dbz  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem      <= w_rem_next;
          r_quot     <= {r_quot[QW-2:0], w_qbit};
          r_dividend <= {r_dividend[QW-2:0], 1'b0};
          r_cnt      <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cl_seq_div.sv
// Bench for cl_seq_div at W=8: directed cases, backpressure hold, mid-op
// reset and randomized operands against an arithmetic reference model.
module tb_cl_seq_div;

  localparam int W  = 8;
  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          carry_option = 1'b0;
  logic [QW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
  logic [1:0]    dbg_state;

  logic [QW+W:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rdy_mode = 0;

  cl_seq_div #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .carry_option (carry_option),
    .dividend     (dividend),
    .divisor      (divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {quotient, remainder, div_by_zero} from plain arithmetic.
  function automatic logic [QW+W:0] ref_div(input logic [QW-1:0] a, input logic [W-1:0] b,
                                             input logic m);
    logic [QW-1:0] q, r;
    int db;
    if (b == '0) return {{QW{1'b1}}, a[W-1:0], 1'b1};
    if (m) begin
      q = a / QW'(b);
      r = a % QW'(b);
    end else begin
      db = 0;
      for (int i = 0; i < W; i++) if (b[i]) db = i;
      r = a;
      q = '0;
      for (int i = QW - 1; i >= db; i--) begin
        if (r[i]) begin
          r = r ^ (QW'(b) << (i - db));
          q[i - db] = 1'b1;
        end
      end
    end
    return {q, r[W-1:0], 1'b0};
  endfunction

  // ---------------- consumer backpressure ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  logic [QW+W:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none", {quotient, remainder, div_by_zero});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {quotient, remainder, div_by_zero}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [QW-1:0] a, input logic [W-1:0] b, input logic m,
                          input bit push);
    int n = 0;
    if (push) exp_q.push_back(ref_div(a, b, m));
    @(posedge clk); #1;
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    carry_option = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = QW'($urandom);
    divisor = W'($urandom);
    carry_option = ~m;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", out_valid, 0);
  endtask

  task automatic run_op(input logic [QW-1:0] a, input logic [W-1:0] b, input logic m,
                        input int exp_lat);
    int lat;
    start_op(a, b, m, 1'b1);
    wait_valid(lat);
    chk("latency", lat, exp_lat);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  logic [QW+W:0] snap;
  logic [W-1:0]  rb;
  int            lat;

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 0;
    run_op(16'h000B, 8'h03, 1'b0, 17);
    run_op(16'h000B, 8'h03, 1'b1, 17);
    run_op(16'h1234, 8'h56, 1'b1, 17);
    run_op(16'h0009, 8'h03, 1'b0, 17);
    run_op(16'hFFFF, 8'h01, 1'b0, 17);
    run_op(16'hFFFF, 8'h01, 1'b1, 17);
    run_op(16'hABCD, 8'h00, 1'b0, 1);
    run_op(16'hABCD, 8'h00, 1'b1, 1);
    run_op(16'hFFFF, 8'hFF, 1'b0, 17);
    run_op(16'h8001, 8'h80, 1'b1, 17);

    // Result held under backpressure while new operands are offered.
    rdy_mode = 2;
    start_op(16'h1234, 8'h56, 1'b1, 1'b1);
    wait_valid(lat);
    chk("hold_latency", lat, 17);
    snap = {quotient, remainder, div_by_zero};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      dividend = QW'($urandom);
      divisor = W'($urandom);
      carry_option = 1'($urandom);
      @(negedge clk);
      chk("hold_stable", {quotient, remainder, div_by_zero}, snap);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("idle_after_drain", in_ready, 1);
    run_op(16'h00F0, 8'h0B, 1'b0, 17);

    // Reset in the fifth CALC cycle discards the operation.
    start_op(16'h0BEE, 8'h07, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", in_ready, 1);
    run_op(16'h0BEE, 8'h07, 1'b1, 17);

    // Randomized operands, modes and consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      run_op(QW'($urandom), rb, 1'($urandom), (rb == 8'h00) ? 1 : 17);
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
